// File: rtl/xcache_rr_sched.sv
// Round-robin scheduler that shares one xcache port among RV_NUM requesters.
// Reads in flight are tagged in an in-order FIFO so responses reach the issuer.

module xcache_rr_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  set_pend,
  input  logic                  pop_hit,
  input  logic [DATA_WIDTH-1:0] mem_do,
  output logic                  pend,
  output logic                  rv_valid,
  output logic [DATA_WIDTH-1:0] rv_rdata
);
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // A lane cannot be pushed and popped together (pending blocks reads), set wins anyway.
  always_comb begin
    pend_d  = pend_q;
    if (pop_hit)  pend_d = 1'b0;
    if (set_pend) pend_d = 1'b1;
    valid_d = pop_hit;
    rdata_d = pop_hit ? mem_do : rdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  assign pend     = pend_q;
  assign rv_valid = valid_q;
  assign rv_rdata = rdata_q;
endmodule

module xcache_rr_sched #(
  parameter int RV_NUM      = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_OUT     = 2,
  parameter int RV_IDX_BITS = (RV_NUM == 1) ? 1 : $clog2(RV_NUM),
  parameter int CNT_BITS    = $clog2(MAX_OUT + 1)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [RV_NUM-1:0][7:0]               rv_part,
  input  logic [RV_NUM-1:0]                    rv_re,
  input  logic [RV_NUM-1:0][3:0]               rv_we,
  input  logic [RV_NUM-1:0][ADDR_WIDTH-1:0]    rv_addr,
  input  logic [RV_NUM-1:0][DATA_WIDTH-1:0]    rv_wdata,
  output logic [RV_NUM-1:0]                    rv_ready,
  output logic [RV_NUM-1:0]                    rv_valid,
  output logic [RV_NUM-1:0][DATA_WIDTH-1:0]    rv_rdata,
  input  logic                                 mem_rdy,
  output logic [7:0]                           mem_part,
  output logic                                 mem_re,
  output logic [3:0]                           mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_ad,
  output logic [DATA_WIDTH-1:0]                mem_di,
  input  logic [DATA_WIDTH-1:0]                mem_do,
  input  logic                                 mem_do_vld,
  output logic [CNT_BITS-1:0]                  out_cnt,
  output logic                                 err_unexp_rsp
);
  localparam int PTR_W  = (MAX_OUT == 1) ? 1 : $clog2(MAX_OUT);
  localparam int FIFO_D = 1 << PTR_W;
  localparam int IW     = RV_IDX_BITS + 1;

  logic [RV_IDX_BITS-1:0]              rr_ptr_q, rr_ptr_d, gnt, head_idx;
  logic [PTR_W-1:0]                    head_q, head_d, tail_q, tail_d;
  logic [FIFO_D-1:0][RV_IDX_BITS-1:0]  tag_q, tag_d;
  logic [CNT_BITS-1:0]                 out_cnt_q, out_cnt_d;
  logic                                err_q, err_d;
  logic [RV_NUM-1:0]                   req, elig, pend, set_pend, pop_hit;
  logic [IW-1:0]                       idx, nxt;
  logic                                gnt_vld, gnt_re, fifo_full, accept, rd_acc, pop;

  // Eligibility and rotating-priority grant starting at rr_ptr.
  always_comb begin
    fifo_full = (out_cnt_q == CNT_BITS'(MAX_OUT));
    for (int i = 0; i < RV_NUM; i++) begin
      req[i]  = rv_re[i] | (rv_we[i] != 4'h0);
      elig[i] = req[i] & ~pend[i] & ~(rv_re[i] & fifo_full);
    end
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < RV_NUM; k++) begin
      idx = {1'b0, rr_ptr_q} + IW'(k);
      if (idx >= IW'(RV_NUM)) idx = idx - IW'(RV_NUM);
      if (!gnt_vld && elig[idx[RV_IDX_BITS-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[RV_IDX_BITS-1:0];
      end
    end
  end

  always_comb begin
    gnt_re   = rv_re[gnt];
    mem_part = rv_part[gnt];
    mem_ad   = rv_addr[gnt];
    mem_di   = rv_wdata[gnt];
    mem_re   = gnt_vld & gnt_re;
    mem_we   = (gnt_vld & ~gnt_re) ? rv_we[gnt] : 4'h0;
    accept   = gnt_vld & mem_rdy;
    rd_acc   = accept & gnt_re;
    pop      = mem_do_vld & (out_cnt_q != '0);
    head_idx = tag_q[head_q];
    rv_ready = '0;
    if (accept) rv_ready[gnt] = 1'b1;
    for (int i = 0; i < RV_NUM; i++) begin
      set_pend[i] = rd_acc & (gnt == RV_IDX_BITS'(i));
      pop_hit[i]  = pop & (head_idx == RV_IDX_BITS'(i));
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    nxt       = {1'b0, gnt} + IW'(1);
    if (nxt >= IW'(RV_NUM)) nxt = nxt - IW'(RV_NUM);
    if (accept) rr_ptr_d = nxt[RV_IDX_BITS-1:0];
    tag_d     = tag_q;
    tail_d    = tail_q;
    head_d    = head_q;
    out_cnt_d = out_cnt_q;
    if (rd_acc) begin
      tag_d[tail_q] = gnt;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    case ({rd_acc, pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
    // A response with nothing outstanding is dropped and latched as an error.
    err_d = err_q | (mem_do_vld & ~pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      tag_q     <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      tag_q     <= tag_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RV_NUM; gi++) begin : g_lane
      xcache_rr_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk      (clk),
        .rstn     (rstn),
        .set_pend (set_pend[gi]),
        .pop_hit  (pop_hit[gi]),
        .mem_do   (mem_do),
        .pend     (pend[gi]),
        .rv_valid (rv_valid[gi]),
        .rv_rdata (rv_rdata[gi])
      );
    end
  endgenerate

  assign out_cnt       = out_cnt_q;
  assign err_unexp_rsp = err_q;
endmodule

// File: tb/tb_xcache_rr_sched.sv
// Directed bench for xcache_rr_sched with hand-computed expectations (RV_NUM=4, MAX_OUT=2).
module tb_xcache_rr_sched;
  logic             clk = 1'b0;
  logic             rstn;
  logic [3:0][7:0]  rv_part;
  logic [3:0]       rv_re;
  logic [3:0][3:0]  rv_we;
  logic [3:0][31:0] rv_addr, rv_wdata;
  logic [3:0]       rv_ready, rv_valid;
  logic [3:0][31:0] rv_rdata;
  logic             mem_rdy;
  logic [7:0]       mem_part;
  logic             mem_re;
  logic [3:0]       mem_we;
  logic [31:0]      mem_ad, mem_di, mem_do;
  logic             mem_do_vld;
  logic [1:0]       out_cnt;
  logic             err_unexp_rsp;
  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  xcache_rr_sched dut (
    .clk(clk), .rstn(rstn), .rv_part(rv_part), .rv_re(rv_re), .rv_we(rv_we),
    .rv_addr(rv_addr), .rv_wdata(rv_wdata), .rv_ready(rv_ready), .rv_valid(rv_valid),
    .rv_rdata(rv_rdata), .mem_rdy(mem_rdy), .mem_part(mem_part), .mem_re(mem_re),
    .mem_we(mem_we), .mem_ad(mem_ad), .mem_di(mem_di), .mem_do(mem_do),
    .mem_do_vld(mem_do_vld), .out_cnt(out_cnt), .err_unexp_rsp(err_unexp_rsp)
  );

  task automatic clr_in();
    rv_re = '0; rv_we = '0; mem_rdy = 1'b0; mem_do = '0; mem_do_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv_part[i] = 8'(i + 8'h40); rv_addr[i] = 32'(i * 16); rv_wdata[i] = 32'(32'hD0 + i);
    end
  endtask

  task automatic tic();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0; clr_in();
    @(negedge clk); rstn = 1'b1;
    tic();
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr_in(); #12;
    chk_cnt++; if (rv_valid !== 4'h0) $display("FAIL rst_valid got %h exp 0", rv_valid); else pass_cnt++;
    chk_cnt++; if (out_cnt !== 2'd0) $display("FAIL rst_cnt got %0d exp 0", out_cnt); else pass_cnt++;
    chk_cnt++; if (err_unexp_rsp !== 1'b0) $display("FAIL rst_err got %b exp 0", err_unexp_rsp); else pass_cnt++;
    chk_cnt++; if (rv_rdata !== '0) $display("FAIL rst_rdata got %h exp 0", rv_rdata); else pass_cnt++;
    chk_cnt++; if ({mem_re, mem_we, rv_ready} !== 9'h0) $display("FAIL rst_mem got %h exp 0", {mem_re, mem_we, rv_ready}); else pass_cnt++;
    @(negedge clk); rstn = 1'b1; tic();
  endtask

  task automatic test_single_read();
    do_reset();
    rv_re = 4'b0100; rv_addr[2] = 32'h100; mem_rdy = 1'b1; #1;
    chk_cnt++; if (mem_re !== 1'b1 || mem_we !== 4'h0) $display("FAIL sr_strobe got re=%b we=%h exp re=1 we=0", mem_re, mem_we); else pass_cnt++;
    chk_cnt++; if (mem_ad !== 32'h100) $display("FAIL sr_addr got %h exp 100", mem_ad); else pass_cnt++;
    chk_cnt++; if (mem_part !== 8'h42) $display("FAIL sr_part got %h exp 42", mem_part); else pass_cnt++;
    chk_cnt++; if (rv_ready !== 4'b0100) $display("FAIL sr_ready got %b exp 0100", rv_ready); else pass_cnt++;
    tic(); rv_re = '0;
    chk_cnt++; if (out_cnt !== 2'd1) $display("FAIL sr_cnt1 got %0d exp 1", out_cnt); else pass_cnt++;
    tic(); tic();
    mem_do_vld = 1'b1; mem_do = 32'hDEAD;
    tic(); mem_do_vld = 1'b0;
    chk_cnt++; if (rv_valid !== 4'b0100) $display("FAIL sr_valid got %b exp 0100", rv_valid); else pass_cnt++;
    chk_cnt++; if (rv_rdata[2] !== 32'hDEAD) $display("FAIL sr_rdata got %h exp dead", rv_rdata[2]); else pass_cnt++;
    chk_cnt++; if (out_cnt !== 2'd0) $display("FAIL sr_cnt0 got %0d exp 0", out_cnt); else pass_cnt++;
    tic();
    chk_cnt++; if (rv_valid !== 4'b0000) $display("FAIL sr_pulse got %b exp 0000", rv_valid); else pass_cnt++;
    chk_cnt++; if (rv_rdata[2] !== 32'hDEAD) $display("FAIL sr_hold got %h exp dead", rv_rdata[2]); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    rv_we = {4{4'hF}}; mem_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++; if (rv_ready !== 4'(1 << exp_g[c]) || mem_ad !== 32'(exp_g[c] * 16))
        $display("FAIL rr_grant%0d got ready=%b ad=%h exp grant %0d", c, rv_ready, mem_ad, exp_g[c]); else pass_cnt++;
      tic();
    end
    mem_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_cnt++; if (rv_ready !== 4'b0000 || mem_ad !== 32'h10 || mem_we !== 4'hF)
        $display("FAIL rr_stall%0d got ready=%b ad=%h we=%h exp 0000/10/f", c, rv_ready, mem_ad, mem_we); else pass_cnt++;
      tic();
    end
    mem_rdy = 1'b1; #1;
    chk_cnt++; if (rv_ready !== 4'b0010) $display("FAIL rr_resume got %b exp 0010", rv_ready); else pass_cnt++;
    tic(); #1;
    chk_cnt++; if (rv_ready !== 4'b0100) $display("FAIL rr_next got %b exp 0100", rv_ready); else pass_cnt++;
    rv_we = '0; tic();
  endtask

  task automatic test_outstanding();
    do_reset();
    rv_re = 4'b0111; mem_rdy = 1'b1; #1;
    chk_cnt++; if (rv_ready !== 4'b0001) $display("FAIL os_g0 got %b exp 0001", rv_ready); else pass_cnt++;
    tic(); rv_re = 4'b0110; #1;
    chk_cnt++; if (rv_ready !== 4'b0010) $display("FAIL os_g1 got %b exp 0010", rv_ready); else pass_cnt++;
    tic(); rv_re = 4'b0100; rv_we[3] = 4'hF; #1;
    chk_cnt++; if (out_cnt !== 2'd2) $display("FAIL os_full got %0d exp 2", out_cnt); else pass_cnt++;
    chk_cnt++; if (rv_ready !== 4'b1000 || mem_we !== 4'hF || mem_re !== 1'b0)
      $display("FAIL os_wr got ready=%b we=%h re=%b exp 1000/f/0", rv_ready, mem_we, mem_re); else pass_cnt++;
    tic(); rv_we[3] = 4'h0; mem_do_vld = 1'b1; mem_do = 32'hA; #1;
    chk_cnt++; if (rv_ready !== 4'b0000 || mem_re !== 1'b0) $display("FAIL os_stall got ready=%b re=%b exp 0000/0", rv_ready, mem_re); else pass_cnt++;
    tic(); mem_do_vld = 1'b0;
    chk_cnt++; if (rv_valid !== 4'b0001 || rv_rdata[0] !== 32'hA) $display("FAIL os_rsp0 got v=%b d=%h exp 0001/a", rv_valid, rv_rdata[0]); else pass_cnt++;
    #1;
    chk_cnt++; if (rv_ready !== 4'b0100) $display("FAIL os_g2 got %b exp 0100", rv_ready); else pass_cnt++;
    tic(); rv_re = '0; mem_do_vld = 1'b1; mem_do = 32'hB;
    chk_cnt++; if (out_cnt !== 2'd2) $display("FAIL os_cnt2 got %0d exp 2", out_cnt); else pass_cnt++;
    tic(); mem_do = 32'hC;
    chk_cnt++; if (rv_valid !== 4'b0010 || rv_rdata[1] !== 32'hB) $display("FAIL os_rsp1 got v=%b d=%h exp 0010/b", rv_valid, rv_rdata[1]); else pass_cnt++;
    tic(); mem_do_vld = 1'b0;
    chk_cnt++; if (rv_valid !== 4'b0100 || rv_rdata[2] !== 32'hC || out_cnt !== 2'd0)
      $display("FAIL os_rsp2 got v=%b d=%h cnt=%0d exp 0100/c/0", rv_valid, rv_rdata[2], out_cnt); else pass_cnt++;
  endtask

  task automatic test_pending_block();
    do_reset();
    rv_re = 4'b0010; mem_rdy = 1'b1; #1;
    chk_cnt++; if (rv_ready !== 4'b0010) $display("FAIL pb_first got %b exp 0010", rv_ready); else pass_cnt++;
    tic(); #1;
    chk_cnt++; if (rv_ready !== 4'b0000) $display("FAIL pb_block0 got %b exp 0000", rv_ready); else pass_cnt++;
    tic(); mem_do_vld = 1'b1; mem_do = 32'h11; #1;
    chk_cnt++; if (rv_ready !== 4'b0000) $display("FAIL pb_block1 got %b exp 0000", rv_ready); else pass_cnt++;
    tic(); mem_do_vld = 1'b0; #1;
    chk_cnt++; if (rv_valid !== 4'b0010 || rv_ready !== 4'b0010)
      $display("FAIL pb_reissue got valid=%b ready=%b exp 0010/0010", rv_valid, rv_ready); else pass_cnt++;
    tic(); rv_re = '0;
    chk_cnt++; if (out_cnt !== 2'd1) $display("FAIL pb_cnt got %0d exp 1", out_cnt); else pass_cnt++;
    mem_do_vld = 1'b1; tic(); mem_do_vld = 1'b0;
  endtask

  task automatic test_push_pop_wrap();
    int prev;
    do_reset();
    rv_re = 4'b0001; mem_rdy = 1'b1;
    tic();
    prev = 0;
    for (int k = 1; k < 6; k++) begin
      rv_re = 4'(1 << (k % 4)); mem_do_vld = 1'b1; mem_do = 32'(32'h200 + k - 1); #1;
      chk_cnt++; if (rv_ready !== 4'(1 << (k % 4))) $display("FAIL pp_ready%0d got %b exp %b", k, rv_ready, 4'(1 << (k % 4))); else pass_cnt++;
      tic();
      chk_cnt++; if (out_cnt !== 2'd1 || rv_valid !== 4'(1 << prev) || rv_rdata[prev] !== 32'(32'h200 + k - 1))
        $display("FAIL pp_pop%0d got cnt=%0d v=%b d=%h exp 1/%b/%h", k, out_cnt, rv_valid, rv_rdata[prev], 4'(1 << prev), 32'(32'h200 + k - 1)); else pass_cnt++;
      prev = k % 4;
    end
    rv_re = '0; mem_do = 32'h205;
    tic(); mem_do_vld = 1'b0;
    chk_cnt++; if (out_cnt !== 2'd0 || rv_valid !== 4'b0010 || rv_rdata[1] !== 32'h205)
      $display("FAIL pp_last got cnt=%0d v=%b d=%h exp 0/0010/205", out_cnt, rv_valid, rv_rdata[1]); else pass_cnt++;
  endtask

  task automatic test_unexpected();
    do_reset();
    mem_do_vld = 1'b1; mem_do = 32'h77;
    tic(); mem_do_vld = 1'b0;
    chk_cnt++; if (err_unexp_rsp !== 1'b1 || rv_valid !== 4'h0 || out_cnt !== 2'd0)
      $display("FAIL ue_flag got err=%b v=%b cnt=%0d exp 1/0000/0", err_unexp_rsp, rv_valid, out_cnt); else pass_cnt++;
    rv_re = 4'b1000; mem_rdy = 1'b1;
    tic(); rv_re = '0; mem_do_vld = 1'b1; mem_do = 32'h55;
    tic(); mem_do_vld = 1'b0;
    chk_cnt++; if (err_unexp_rsp !== 1'b1 || rv_rdata[3] !== 32'h55)
      $display("FAIL ue_sticky got err=%b d=%h exp 1/55", err_unexp_rsp, rv_rdata[3]); else pass_cnt++;
    rv_re = 4'b1000;
    tic(); rv_re = '0;
    chk_cnt++; if (out_cnt !== 2'd1) $display("FAIL ue_inflight got %0d exp 1", out_cnt); else pass_cnt++;
    rstn = 1'b0; #1;
    chk_cnt++; if (out_cnt !== 2'd0 || err_unexp_rsp !== 1'b0 || rv_valid !== 4'h0 || rv_rdata !== '0)
      $display("FAIL ue_reset got cnt=%0d err=%b v=%b d3=%h exp 0/0/0000/0", out_cnt, err_unexp_rsp, rv_valid, rv_rdata[3]); else pass_cnt++;
    @(negedge clk); rstn = 1'b1;
    tic(); mem_do_vld = 1'b1; mem_do = 32'h66;
    tic(); mem_do_vld = 1'b0;
    chk_cnt++; if (err_unexp_rsp !== 1'b1 || rv_valid !== 4'h0)
      $display("FAIL ue_late got err=%b v=%b exp 1/0000", err_unexp_rsp, rv_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_outstanding();
    test_pending_block();
    test_push_pop_wrap();
    test_unexpected();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
